wptr_full_gen: RTL and testbench

- Write-domain pointer and full-flag generator for the asynchronous FIFO.
- Maintains the binary and Gray write pointers and drives the write address into the dual-port RAM.
- Publishes the Gray write pointer toward the read-domain 2-FF synchronizer.
- Consumes the Gray read pointer already synchronized into the write clock domain, and derives full, almost-full and overflow status from it.

---
 rtl/wptr_full_gen.sv | 102 ++++++++++
 tb/tb_wptr_full_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_gen.sv
// Write-domain pointer and full-flag generator for an asynchronous FIFO.
// Keeps the binary/Gray write pointers, drives the RAM write address and derives
// full, almost-full and sticky overflow from the synchronized Gray read pointer.
// Optional feature: define WFIFO_LEVEL_EN to expose the registered fill level
// on o_wlevel.

module wptr_full_gen #(
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned AF_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_winc,
    input  logic [ADDR_SIZE:0]   i_wq2_rptr,
    input  logic                 i_ovf_clr,
    output logic [ADDR_SIZE-1:0] o_waddr,
    output logic [ADDR_SIZE:0]   o_wptr,
    output logic                 o_wfull,
    output logic                 o_walmost_full,
    output logic                 o_wovf
`ifdef WFIFO_LEVEL_EN
    ,
    output logic [ADDR_SIZE:0]   o_wlevel
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] AF_THRESH = (ADDR_SIZE + 1)'(DEPTH - AF_MARGIN);

    logic [ADDR_SIZE:0] wbin_q, wbin_d;
    logic [ADDR_SIZE:0] wptr_q, wptr_d;
    logic               wfull_q, wfull_d;
    logic               walmost_full_q, walmost_full_d;
    logic               wovf_q, wovf_d;
    logic [ADDR_SIZE:0] rbin;
    logic [ADDR_SIZE:0] level_d;
    logic               waccept;

    // Pointer advance and Gray conversion of the next write pointer.
    always_comb begin
        waccept = i_winc & ~wfull_q;
        wbin_d  = wbin_q + (ADDR_SIZE + 1)'(waccept);
        wptr_d  = (wbin_d >> 1) ^ wbin_d;
    end

    // Gray-to-binary of the read pointer: bit i is the XOR of bits i..MSB.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            rbin[i] = ^(i_wq2_rptr >> i);
        end
    end

    // Status next-state; uses the post-write pointer and the current read pointer.
    always_comb begin
        level_d        = wbin_d - rbin;
        wfull_d        = (wptr_d == {~i_wq2_rptr[ADDR_SIZE:ADDR_SIZE-1],
                                     i_wq2_rptr[ADDR_SIZE-2:0]});
        walmost_full_d = (level_d >= AF_THRESH);
        // A dropped write sets overflow; set has priority over clear.
        wovf_d         = (i_winc & wfull_q) | (wovf_q & ~i_ovf_clr);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wovf_q         <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wovf_q         <= wovf_d;
        end
    end

`ifdef WFIFO_LEVEL_EN
    logic [ADDR_SIZE:0] wlevel_q;

    // Fill level register, same timing as the full flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wlevel_q <= '0;
        end else begin
            wlevel_q <= level_d;
        end
    end

    assign o_wlevel = wlevel_q;
`endif

    assign o_waddr        = wbin_q[ADDR_SIZE-1:0];
    assign o_wptr         = wptr_q;
    assign o_wfull        = wfull_q;
    assign o_walmost_full = walmost_full_q;
    assign o_wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full_gen.sv
// Self-checking bench for wptr_full_gen (ADDR_SIZE=4, AF_MARGIN=2).
// Reference model tracks accepted-write and read counts as plain integers.

module tb_wptr_full_gen;

    localparam int unsigned AS    = 4;
    localparam int unsigned AF    = 2;
    localparam int          DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          winc = 1'b0;
    logic          clr = 1'b0;
    logic [AS:0]   rptr = '0;
    logic [AS-1:0] waddr;
    logic [AS:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic          wovf;
`ifdef WFIFO_LEVEL_EN
    logic [AS:0]   wlevel;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    int wcnt = 0;
    int rcnt = 0;
    int m_level = 0;
    bit m_full = 1'b0;
    bit m_af = 1'b0;
    bit m_ovf = 1'b0;

    wptr_full_gen #(
        .ADDR_SIZE(AS),
        .AF_MARGIN(AF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_winc        (winc),
        .i_wq2_rptr    (rptr),
        .i_ovf_clr     (clr),
        .o_waddr       (waddr),
        .o_wptr        (wptr),
        .o_wfull       (wfull),
        .o_walmost_full(walmost_full),
        .o_wovf        (wovf)
`ifdef WFIFO_LEVEL_EN
        ,
        .o_wlevel      (wlevel)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [AS:0] gray_of(input int n);
        logic [AS:0] b;
        b = (AS + 1)'(n % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".wptr"}, 32'(wptr), 32'(gray_of(wcnt)));
        chk({tag, ".waddr"}, 32'(waddr), 32'(wcnt % DEPTH));
        chk({tag, ".wfull"}, 32'(wfull), 32'(m_full));
        chk({tag, ".walmost_full"}, 32'(walmost_full), 32'(m_af));
        chk({tag, ".wovf"}, 32'(wovf), 32'(m_ovf));
`ifdef WFIFO_LEVEL_EN
        chk({tag, ".wlevel"}, 32'(wlevel), 32'(m_level));
`endif
    endtask

    task automatic model_reset();
        wcnt    = 0;
        rcnt    = 0;
        m_level = 0;
        m_full  = 1'b0;
        m_af    = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // One clock with the given write/clear request; read pointer follows rcnt.
    task automatic cycle(input bit w, input bit c, input string tag);
        bit          acc;
        int          wn;
        int          lvl;
        logic [AS:0] prev;
        winc = w;
        clr  = c;
        rptr = gray_of(rcnt);
        acc  = w && !m_full;
        wn   = wcnt + (acc ? 1 : 0);
        lvl  = wn - rcnt;
        prev = wptr;
        @(posedge clk);
        #1;
        m_ovf   = (w && m_full) || (m_ovf && !c);
        wcnt    = wn;
        m_level = lvl;
        m_full  = (lvl == DEPTH);
        m_af    = (DEPTH - lvl) <= AF;
        if (acc) begin
            chk({tag, ".gray_step"}, 32'($countones(prev ^ wptr)), 32'd1);
        end
        check_all(tag);
    endtask

    // Assert reset between clock edges and verify outputs clear immediately.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        winc = 1'b1;
        rptr = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_all({tag, ".hold"});
        end
        winc = 1'b0;
        rst  = 1'b1;
    endtask

    initial begin
        // Reset held with write requested.
        winc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_all("reset_hold");
        end
        winc = 1'b0;
        rst  = 1'b1;

        // Fill to almost-full then full with the read pointer at zero.
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, "fill");
        chk("af_at_14", 32'(walmost_full), 32'd1);
        chk("notfull_at_14", 32'(wfull), 32'd0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, "fill");
        chk("full_at_16", 32'(wfull), 32'd1);
        chk("wptr_at_16", 32'(wptr), 32'h18);
        chk("waddr_at_16", 32'(waddr), 32'd0);

        // Writes while full are dropped and set overflow; set beats clear.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "ovf");
        chk("ovf_set", 32'(wovf), 32'd1);
        chk("wptr_held", 32'(wptr), 32'h18);
        cycle(1'b1, 1'b1, "ovf_set_wins");
        chk("ovf_set_wins", 32'(wovf), 32'd1);
        cycle(1'b0, 1'b1, "ovf_clr");
        chk("ovf_cleared", 32'(wovf), 32'd0);

        // Read advance releases full; refill; simultaneous write and read.
        rcnt = 1;
        cycle(1'b0, 1'b0, "read_adv");
        chk("full_released", 32'(wfull), 32'd0);
        cycle(1'b1, 1'b0, "refill");
        chk("refull", 32'(wfull), 32'd1);
        rcnt = 2;
        cycle(1'b0, 1'b0, "read_adv2");
        rcnt = 3;
        cycle(1'b1, 1'b0, "wr_rd_same");
        chk("wr_rd_same_notfull", 32'(wfull), 32'd0);

        // Pointer wrap from reset with the read pointer trailing by one write.
        async_reset("rst_before_wrap");
        for (int i = 0; i < 31; i++) begin
            rcnt = wcnt;
            cycle(1'b1, 1'b0, "wrap");
        end
        chk("wptr_gray31", 32'(wptr), 32'h10);
        rcnt = wcnt;
        cycle(1'b1, 1'b0, "wrap");
        chk("wptr_wrapped", 32'(wptr), 32'h00);
        chk("waddr_wrapped", 32'(waddr), 32'd0);

        // Randomized traffic; read count never passes the write count.
        for (int i = 0; i < 600; i++) begin
            if (rcnt < wcnt && $urandom_range(0, 2) == 0) begin
                rcnt = rcnt + int'($urandom_range(1, 2));
                if (rcnt > wcnt) rcnt = wcnt;
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, "rand");
        end

        // Asynchronous reset mid-burst at level 9, then first write lands at 0.
        rcnt = wcnt;
        cycle(1'b0, 1'b1, "drain");
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, "burst");
        async_reset("rst_mid_burst");
        chk("waddr_first_write", 32'(waddr), 32'd0);
        cycle(1'b1, 1'b0, "first_write");
        chk("wptr_first_write", 32'(wptr), 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
